// File: rtl/oc_sensor_monitor_pkg.sv
// Shared register map, control bit positions and mode encoding for oc_sensor_monitor.
package oclib_pkg;

    localparam logic [2:0] SensorMonOffsetAverage  = 3'd0;
    localparam logic [2:0] SensorMonOffsetMin      = 3'd1;
    localparam logic [2:0] SensorMonOffsetMax      = 3'd2;
    localparam logic [2:0] SensorMonOffsetWarnHigh = 3'd3;
    localparam logic [2:0] SensorMonOffsetWarnLow  = 3'd4;
    localparam logic [2:0] SensorMonOffsetErrHigh  = 3'd5;
    localparam logic [2:0] SensorMonOffsetErrLow   = 3'd6;
    localparam logic [2:0] SensorMonOffsetControl  = 3'd7;

    localparam int SensorMonCtrlBitMode       = 0;
    localparam int SensorMonCtrlBitEnable     = 1;
    localparam int SensorMonCtrlBitWarning    = 8;
    localparam int SensorMonCtrlBitError      = 9;
    localparam int SensorMonCtrlBitStickyWarn = 16;
    localparam int SensorMonCtrlBitStickyErr  = 17;

    typedef enum logic {
        OverLimit = 1'b0,
        Window    = 1'b1
    } sensor_mon_mode_e;

endpackage

// File: rtl/oc_sensor_monitor_if.sv
// Sample stream, config bus and flag outputs of oc_sensor_monitor.
interface oc_sensor_monitor_if #(
    parameter int NumChannels  = 4,
    parameter int DataWidth    = 16,
    parameter int AddressWidth = 8
);
    logic                    sampleValid;
    logic [3:0]              sampleChannel;
    logic [DataWidth-1:0]    sampleData;
    logic                    cfgWrite;
    logic                    cfgRead;
    logic [AddressWidth-1:0] cfgAddress;
    logic [31:0]             cfgWdata;
    logic [31:0]             cfgRdata;
    logic                    cfgReady;
    logic [NumChannels-1:0]  warning;
    logic [NumChannels-1:0]  error;
    logic                    anyWarning;
    logic                    anyError;
    logic                    alert;

    modport master (
        output sampleValid, sampleChannel, sampleData,
        output cfgWrite, cfgRead, cfgAddress, cfgWdata,
        input  cfgRdata, cfgReady, warning, error, anyWarning, anyError, alert
    );

    modport slave (
        input  sampleValid, sampleChannel, sampleData,
        input  cfgWrite, cfgRead, cfgAddress, cfgWdata,
        output cfgRdata, cfgReady, warning, error, anyWarning, anyError, alert
    );
endinterface

// File: rtl/oc_sensor_monitor_channel.sv
// One monitored channel: block averager, min/max, thresholds, flags and sticky bits.
// Min/max tracking is present only when OC_SENSOR_MONITOR_MINMAX_EN is defined.
module oc_sensor_monitor_channel
    import oclib_pkg::*;
#(
    parameter int DataWidth    = 16,
    parameter int AverageShift = 6
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 sample_valid,
    input  logic [DataWidth-1:0] sample_data,
    input  logic                 wr_en,
    input  logic [2:0]           offset,
    input  logic [31:0]          wdata,
    output logic [31:0]          rd_data,
    output logic                 warning,
    output logic                 error,
    output logic                 sticky_warn,
    output logic                 sticky_err
);
    localparam int AccWidth = DataWidth + AverageShift;
    localparam int CntWidth = (AverageShift > 0) ? AverageShift : 1;

    logic [AccWidth-1:0]  acc_q, acc_d, sum;
    logic [CntWidth-1:0]  cnt_q, cnt_d;
    logic [DataWidth-1:0] avg_q, avg_d, new_avg;
    logic [DataWidth-1:0] warn_high_q, warn_high_d, warn_low_q, warn_low_d;
    logic [DataWidth-1:0] err_high_q, err_high_d, err_low_q, err_low_d;
    sensor_mon_mode_e     mode_q, mode_d;
    logic                 enable_q, enable_d;
    logic                 eval_q, eval_d;
    logic                 warn_q, warn_d, err_q, err_d;
    logic                 sticky_warn_q, sticky_warn_d, sticky_err_q, sticky_err_d;
    logic                 accept, wrap, wr_ctrl;
    logic                 unused_wdata;

    assign unused_wdata = ^wdata;
    assign accept  = sample_valid && enable_q;
    assign wrap    = (AverageShift == 0) || (cnt_q == '1);
    assign sum     = acc_q + AccWidth'(sample_data);
    assign new_avg = DataWidth'(sum >> AverageShift);
    assign wr_ctrl = wr_en && (offset == SensorMonOffsetControl);

    always_comb begin
        acc_d         = acc_q;
        cnt_d         = cnt_q;
        avg_d         = avg_q;
        eval_d        = 1'b0;
        warn_high_d   = warn_high_q;
        warn_low_d    = warn_low_q;
        err_high_d    = err_high_q;
        err_low_d     = err_low_q;
        mode_d        = mode_q;
        enable_d      = enable_q;
        warn_d        = warn_q;
        err_d         = err_q;
        sticky_warn_d = sticky_warn_q;
        sticky_err_d  = sticky_err_q;

        if (accept) begin
            if (wrap) begin
                acc_d  = '0;
                cnt_d  = '0;
                avg_d  = new_avg;
                eval_d = 1'b1;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + CntWidth'(1);
            end
        end

        if (wr_en) begin
            case (offset)
                SensorMonOffsetWarnHigh: warn_high_d = wdata[DataWidth-1:0];
                SensorMonOffsetWarnLow:  warn_low_d  = wdata[DataWidth-1:0];
                SensorMonOffsetErrHigh:  err_high_d  = wdata[DataWidth-1:0];
                SensorMonOffsetErrLow:   err_low_d   = wdata[DataWidth-1:0];
                SensorMonOffsetControl: begin
                    mode_d   = sensor_mon_mode_e'(wdata[SensorMonCtrlBitMode]);
                    enable_d = wdata[SensorMonCtrlBitEnable];
                    if (!wdata[SensorMonCtrlBitEnable]) begin
                        acc_d = '0;
                        cnt_d = '0;
                    end
                end
                default: ;
            endcase
        end

        // Evaluation runs one cycle after the average lands, against the registered thresholds.
        if (eval_q) begin
            if (mode_q == Window) begin
                warn_d = (avg_q > warn_high_q) || (avg_q < warn_low_q);
                err_d  = (avg_q > err_high_q) || (avg_q < err_low_q);
            end else begin
                if (avg_q >= warn_high_q)     warn_d = 1'b1;
                else if (avg_q < warn_low_q)  warn_d = 1'b0;
                if (avg_q >= err_high_q)      err_d  = 1'b1;
                else if (avg_q < err_low_q)   err_d  = 1'b0;
            end
        end

        if (!enable_d) begin
            warn_d = 1'b0;
            err_d  = 1'b0;
        end

        if (wr_ctrl && wdata[SensorMonCtrlBitStickyWarn]) sticky_warn_d = 1'b0;
        if (wr_ctrl && wdata[SensorMonCtrlBitStickyErr])  sticky_err_d  = 1'b0;
        if (warn_d) sticky_warn_d = 1'b1;
        if (err_d)  sticky_err_d  = 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_q         <= '0;
            cnt_q         <= '0;
            avg_q         <= '0;
            eval_q        <= 1'b0;
            warn_high_q   <= '1;
            warn_low_q    <= '1;
            err_high_q    <= '1;
            err_low_q     <= '1;
            mode_q        <= OverLimit;
            enable_q      <= 1'b0;
            warn_q        <= 1'b0;
            err_q         <= 1'b0;
            sticky_warn_q <= 1'b0;
            sticky_err_q  <= 1'b0;
        end else begin
            acc_q         <= acc_d;
            cnt_q         <= cnt_d;
            avg_q         <= avg_d;
            eval_q        <= eval_d;
            warn_high_q   <= warn_high_d;
            warn_low_q    <= warn_low_d;
            err_high_q    <= err_high_d;
            err_low_q     <= err_low_d;
            mode_q        <= mode_d;
            enable_q      <= enable_d;
            warn_q        <= warn_d;
            err_q         <= err_d;
            sticky_warn_q <= sticky_warn_d;
            sticky_err_q  <= sticky_err_d;
        end
    end

`ifdef OC_SENSOR_MONITOR_MINMAX_EN
    logic [DataWidth-1:0] min_q, min_d, max_q, max_d;

    // A reset write colliding with a new average still ends up holding that average.
    always_comb begin
        min_d = min_q;
        max_d = max_q;
        if (wr_en && (offset == SensorMonOffsetMin)) min_d = '1;
        if (wr_en && (offset == SensorMonOffsetMax)) max_d = '0;
        if (accept && wrap) begin
            if (new_avg < min_d) min_d = new_avg;
            if (new_avg > max_d) max_d = new_avg;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            min_q <= '1;
            max_q <= '0;
        end else begin
            min_q <= min_d;
            max_q <= max_d;
        end
    end
`endif

    always_comb begin
        rd_data = '0;
        case (offset)
            SensorMonOffsetAverage:  rd_data = 32'(avg_q);
`ifdef OC_SENSOR_MONITOR_MINMAX_EN
            SensorMonOffsetMin:      rd_data = 32'(min_q);
            SensorMonOffsetMax:      rd_data = 32'(max_q);
`endif
            SensorMonOffsetWarnHigh: rd_data = 32'(warn_high_q);
            SensorMonOffsetWarnLow:  rd_data = 32'(warn_low_q);
            SensorMonOffsetErrHigh:  rd_data = 32'(err_high_q);
            SensorMonOffsetErrLow:   rd_data = 32'(err_low_q);
            SensorMonOffsetControl: begin
                rd_data[SensorMonCtrlBitMode]       = (mode_q == Window);
                rd_data[SensorMonCtrlBitEnable]     = enable_q;
                rd_data[SensorMonCtrlBitWarning]    = warn_q;
                rd_data[SensorMonCtrlBitError]      = err_q;
                rd_data[SensorMonCtrlBitStickyWarn] = sticky_warn_q;
                rd_data[SensorMonCtrlBitStickyErr]  = sticky_err_q;
            end
            default: rd_data = '0;
        endcase
    end

    assign warning     = warn_q;
    assign error       = err_q;
    assign sticky_warn = sticky_warn_q;
    assign sticky_err  = sticky_err_q;
endmodule

// File: rtl/oc_sensor_monitor.sv
// Multi-channel sensor monitor top: address decode, read mux, summary and alert registers.
// Optional min/max tracking is enabled with OC_SENSOR_MONITOR_MINMAX_EN.
module oc_sensor_monitor
    import oclib_pkg::*;
#(
    parameter int NumChannels  = 4,
    parameter int DataWidth    = 16,
    parameter int AverageShift = 6,
    parameter int AddressWidth = 8
) (
    input  logic               clock,
    input  logic               reset,
    oc_sensor_monitor_if.slave bus
);
    localparam int ChIdxWidth = AddressWidth - 3;
    localparam logic [AddressWidth-1:0] SummaryAddr = AddressWidth'(NumChannels * 8);

    logic [ChIdxWidth-1:0]  addr_ch;
    logic [2:0]             addr_off;
    logic [31:0]            ch_rd [NumChannels];
    logic [NumChannels-1:0] ch_wr, ch_sample, warn, err, sticky_w, sticky_e;
    logic [31:0]            rd_word;
    logic [31:0]            rdata_q, rdata_d;
    logic                   ready_q, ready_d;
    logic                   any_warn_q, any_warn_d, any_err_q, any_err_d, alert_q, alert_d;

    assign addr_ch  = bus.cfgAddress[AddressWidth-1:3];
    assign addr_off = bus.cfgAddress[2:0];

    for (genvar g = 0; g < NumChannels; g++) begin : g_ch
        assign ch_wr[g]     = bus.cfgWrite && (addr_ch == ChIdxWidth'(g));
        assign ch_sample[g] = bus.sampleValid && (bus.sampleChannel == 4'(g));

        oc_sensor_monitor_channel #(
            .DataWidth   (DataWidth),
            .AverageShift(AverageShift)
        ) u_channel (
            .clock       (clock),
            .reset       (reset),
            .sample_valid(ch_sample[g]),
            .sample_data (bus.sampleData),
            .wr_en       (ch_wr[g]),
            .offset      (addr_off),
            .wdata       (bus.cfgWdata),
            .rd_data     (ch_rd[g]),
            .warning     (warn[g]),
            .error       (err[g]),
            .sticky_warn (sticky_w[g]),
            .sticky_err  (sticky_e[g])
        );
    end

    always_comb begin
        rd_word = '0;
        if (bus.cfgAddress == SummaryAddr) begin
            rd_word[NumChannels-1:0]   = warn;
            rd_word[16 +: NumChannels] = err;
        end else begin
            for (int unsigned i = 0; i < NumChannels; i++) begin
                if (addr_ch == ChIdxWidth'(i)) rd_word = ch_rd[i];
            end
        end
        rdata_d    = bus.cfgRead ? rd_word : '0;
        ready_d    = bus.cfgRead || bus.cfgWrite;
        any_warn_d = |warn;
        any_err_d  = |err;
        alert_d    = |{sticky_w, sticky_e};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rdata_q    <= '0;
            ready_q    <= 1'b0;
            any_warn_q <= 1'b0;
            any_err_q  <= 1'b0;
            alert_q    <= 1'b0;
        end else begin
            rdata_q    <= rdata_d;
            ready_q    <= ready_d;
            any_warn_q <= any_warn_d;
            any_err_q  <= any_err_d;
            alert_q    <= alert_d;
        end
    end

    assign bus.cfgRdata   = rdata_q;
    assign bus.cfgReady   = ready_q;
    assign bus.warning    = warn;
    assign bus.error      = err;
    assign bus.anyWarning = any_warn_q;
    assign bus.anyError   = any_err_q;
    assign bus.alert      = alert_q;
endmodule

// File: tb/tb_oc_sensor_monitor.sv
// Directed self-checking bench for oc_sensor_monitor (4 channels, 4-sample averaging).
module tb_oc_sensor_monitor;
    localparam int NC = 4;
    localparam int DW = 16;
    localparam int AS = 2;
    localparam int AW = 8;
`ifdef OC_SENSOR_MONITOR_MINMAX_EN
    localparam bit MinMaxEn = 1'b1;
`else
    localparam bit MinMaxEn = 1'b0;
`endif

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] exp;
    } rd_vec_t;

    typedef struct {
        int          ch;
        logic [15:0] avg;
        logic        warn;
        logic        err;
        logic        alert;
    } eval_vec_t;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    oc_sensor_monitor_if #(.NumChannels(NC), .DataWidth(DW), .AddressWidth(AW)) bus ();

    oc_sensor_monitor #(
        .NumChannels (NC),
        .DataWidth   (DW),
        .AverageShift(AS),
        .AddressWidth(AW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cfg_write(input logic [7:0] addr, input logic [31:0] data);
        bus.cfgWrite   = 1'b1;
        bus.cfgAddress = addr;
        bus.cfgWdata   = data;
        tick();
        bus.cfgWrite = 1'b0;
        check($sformatf("wr_ready@%02h", addr), 32'(bus.cfgReady), 32'd1);
    endtask

    task automatic cfg_read(input logic [7:0] addr, output logic [31:0] data);
        bus.cfgRead    = 1'b1;
        bus.cfgAddress = addr;
        tick();
        bus.cfgRead = 1'b0;
        data = bus.cfgRdata;
        check($sformatf("rd_ready@%02h", addr), 32'(bus.cfgReady), 32'd1);
    endtask

    task automatic send(input logic [3:0] ch, input logic [15:0] data);
        bus.sampleValid   = 1'b1;
        bus.sampleChannel = ch;
        bus.sampleData    = data;
        tick();
        bus.sampleValid = 1'b0;
    endtask

    task automatic send_avg(input logic [3:0] ch, input logic [15:0] data);
        for (int i = 0; i < 4; i++) send(ch, data);
    endtask

    rd_vec_t   rd_tab [12];
    eval_vec_t ev_tab [8];
    logic [31:0] rd;

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus.sampleValid   = 1'b0;
        bus.sampleChannel = '0;
        bus.sampleData    = '0;
        bus.cfgWrite      = 1'b0;
        bus.cfgRead       = 1'b0;
        bus.cfgAddress    = '0;
        bus.cfgWdata      = '0;

        rd_tab[0]  = '{8'h00, 32'h0};
        rd_tab[1]  = '{8'h01, MinMaxEn ? 32'h0000_FFFF : 32'h0};
        rd_tab[2]  = '{8'h02, 32'h0};
        rd_tab[3]  = '{8'h03, 32'h0000_FFFF};
        rd_tab[4]  = '{8'h04, 32'h0000_FFFF};
        rd_tab[5]  = '{8'h05, 32'h0000_FFFF};
        rd_tab[6]  = '{8'h06, 32'h0000_FFFF};
        rd_tab[7]  = '{8'h07, 32'h0};
        rd_tab[8]  = '{8'h19, MinMaxEn ? 32'h0000_FFFF : 32'h0};
        rd_tab[9]  = '{8'h20, 32'h0};
        rd_tab[10] = '{8'h21, 32'h0};
        rd_tab[11] = '{8'hFF, 32'h0};

        ev_tab[0] = '{1, 16'd99,  1'b0, 1'b0, 1'b0};
        ev_tab[1] = '{1, 16'd100, 1'b1, 1'b0, 1'b1};
        ev_tab[2] = '{1, 16'd95,  1'b1, 1'b0, 1'b1};
        ev_tab[3] = '{1, 16'd89,  1'b0, 1'b0, 1'b1};
        ev_tab[4] = '{2, 16'd49,  1'b1, 1'b1, 1'b1};
        ev_tab[5] = '{2, 16'd50,  1'b1, 1'b0, 1'b1};
        ev_tab[6] = '{2, 16'd200, 1'b1, 1'b0, 1'b1};
        ev_tab[7] = '{2, 16'd201, 1'b1, 1'b1, 1'b1};

        tick();
        tick();
        check("rst_outputs", {bus.cfgRdata[15:0], 3'b0, bus.cfgReady, bus.warning, bus.error,
              bus.anyWarning, bus.anyError, bus.alert, 1'b0}, 32'h0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 12; i++) begin
            cfg_read(rd_tab[i].addr, rd);
            check($sformatf("rst_rd@%02h", rd_tab[i].addr), rd, rd_tab[i].exp);
        end

        // Averaging on ch0
        cfg_write(8'h07, 32'h2);
        send(4'd0, 16'd10);
        send(4'd0, 16'd20);
        send(4'd0, 16'd30);
        send(4'd0, 16'd41);
        cfg_read(8'h00, rd);
        check("avg_ch0", rd, 32'd25);
        cfg_read(8'h01, rd);
        check("min_ch0", rd, MinMaxEn ? 32'd25 : 32'd0);
        cfg_read(8'h02, rd);
        check("max_ch0", rd, MinMaxEn ? 32'd25 : 32'd0);
        cfg_write(8'h01, 32'h0);
        cfg_read(8'h01, rd);
        check("min_rst_ch0", rd, MinMaxEn ? 32'h0000_FFFF : 32'd0);

        // Hysteresis on ch1
        cfg_write(8'h0B, 32'd100);
        cfg_write(8'h0C, 32'd90);
        cfg_write(8'h0F, 32'h2);
        for (int i = 0; i < 4; i++) begin
            send_avg(4'(ev_tab[i].ch), ev_tab[i].avg);
            tick();
            check($sformatf("hyst_warn[%0d]", i), 32'(bus.warning[ev_tab[i].ch]), 32'(ev_tab[i].warn));
            check($sformatf("hyst_err[%0d]", i), 32'(bus.error[ev_tab[i].ch]), 32'(ev_tab[i].err));
            tick();
            check($sformatf("hyst_anyerr[%0d]", i), 32'(bus.anyError), 32'(ev_tab[i].err));
            check($sformatf("hyst_alert[%0d]", i), 32'(bus.alert), 32'(ev_tab[i].alert));
        end
        cfg_read(8'h0F, rd);
        check("hyst_sticky", rd, 32'h0001_0002);
        cfg_write(8'h0F, 32'h0001_0002);
        cfg_read(8'h0F, rd);
        check("w1c_sticky", rd, 32'h0000_0002);
        check("w1c_alert", 32'(bus.alert), 32'd0);

        // Window mode on ch2
        cfg_write(8'h15, 32'd200);
        cfg_write(8'h16, 32'd50);
        cfg_write(8'h17, 32'h3);
        for (int i = 4; i < 8; i++) begin
            send_avg(4'(ev_tab[i].ch), ev_tab[i].avg);
            tick();
            check($sformatf("win_warn[%0d]", i), 32'(bus.warning[ev_tab[i].ch]), 32'(ev_tab[i].warn));
            check($sformatf("win_err[%0d]", i), 32'(bus.error[ev_tab[i].ch]), 32'(ev_tab[i].err));
            tick();
            check($sformatf("win_anyerr[%0d]", i), 32'(bus.anyError), 32'(ev_tab[i].err));
            check($sformatf("win_alert[%0d]", i), 32'(bus.alert), 32'(ev_tab[i].alert));
        end
        cfg_read(8'h20, rd);
        check("summary", rd, 32'h0004_0004);

        // Collisions on ch3: threshold write during evaluation, then W1C during flag set
        cfg_write(8'h1B, 32'd100);
        cfg_write(8'h1C, 32'd90);
        cfg_write(8'h1F, 32'h2);
        send_avg(4'd3, 16'd95);
        cfg_write(8'h1B, 32'd50);
        check("old_thresh_warn", 32'(bus.warning[3]), 32'd0);
        send_avg(4'd3, 16'd95);
        cfg_write(8'h1F, 32'h0001_0002);
        check("new_thresh_warn", 32'(bus.warning[3]), 32'd1);
        cfg_read(8'h1F, rd);
        check("set_beats_w1c", rd, 32'h0001_0102);

        // Robustness
        send_avg(4'd7, 16'd1000);
        cfg_read(8'h18, rd);
        check("ch7_ignored_ch3", rd, 32'd95);
        cfg_read(8'h00, rd);
        check("ch7_ignored_ch0", rd, 32'd25);
        cfg_write(8'h00, 32'd1234);
        cfg_read(8'h00, rd);
        check("ro_write_ignored", rd, 32'd25);
        cfg_read(8'hFF, rd);
        check("unmapped_rd", rd, 32'd0);
        tick();
        check("ready_one_cycle", 32'(bus.cfgReady), 32'd0);

        // Reset mid-average
        send(4'd0, 16'd100);
        send(4'd0, 16'd100);
        reset = 1'b1;
        #1;
        check("async_flags", {16'h0, 3'b0, bus.alert, bus.warning, bus.error}, 32'h0);
        tick();
        reset = 1'b0;
        cfg_write(8'h07, 32'h2);
        send_avg(4'd0, 16'd8);
        cfg_read(8'h00, rd);
        check("avg_after_reset", rd, 32'd8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/oc_sensor_monitor.md
# oc_sensor_monitor

Vendor-neutral, parametrised multi-channel sensor monitor that sits downstream of any ADC/sensor sample stream (on-die SYSMON, external I2C ADC, behavioural model). Per channel it computes a power-of-two block average, tracks min/max, and raises warning and error flags against programmable thresholds. Over-limit mode uses hysteresis; window mode alarms outside a band. Summary flags drive throttling and shutdown logic, and sticky bits feed an alert line.

## Interface
- NumChannels, 4: monitored channels, 1..16.
- DataWidth, 16: sample, threshold and average width.
- AverageShift, 6: average over 2^AverageShift samples, 0..8. 0 means no averaging.
- AddressWidth, 8: config address width. Must hold NumChannels*8+1 words.
- clock  input  1  sole clock.
- reset  input  1  asynchronous, active-high reset.
- sampleValid  input  1  sample strobe. May be high every cycle.
- sampleChannel  input  4  channel index. Values >= NumChannels are ignored.
- sampleData  input  DataWidth  unsigned sample.
- cfgWrite / cfgRead  input  1  one-cycle register strobes. Never both high in one cycle.
- cfgAddress  input  AddressWidth  word address.
- cfgWdata  input  32  write data.
- cfgRdata  output  32  read data. Valid while cfgReady is high.
- cfgReady  output  1  one-cycle pulse, exactly 1 cycle after every cfgRead or cfgWrite.
- warning / error  output  NumChannels  live per-channel flags.
- anyWarning / anyError  output  1  OR reductions of warning / error, registered.
- alert  output  1  OR of all sticky bits, registered.

## Operation
- Per-channel register block at base = ch*8. The listed values are offsets within the block.
  - Offset 0: average (RO).
  - Offset 1: min (RO). Any write sets it to all-ones.
  - Offset 2: max (RO). Any write sets it to 0.
  - Offsets 3/4: warnHigh / warnLow (RW).
  - Offsets 5/6: errHigh / errLow (RW).
  - Offset 7: control/status.
    - bit0 mode: 0 = over-limit, 1 = window.
    - bit1 enable.
    - bit8 warning (RO), bit9 error (RO).
    - bit16 stickyWarn (W1C), bit17 stickyErr (W1C).
- Address NumChannels*8 is the summary register, RO:
  - bits [NumChannels-1:0] = warning.
  - bits [NumChannels+15:16] = error.
- Reads of unmapped addresses return 0. Writes to RO or unmapped addresses are ignored. cfgReady still pulses in both cases.
- Averaging:
  - Each accepted sample adds into a (DataWidth+AverageShift)-bit accumulator and increments an AverageShift-bit counter.
  - On the sample that wraps the counter to 0:
    - average <= (acc+sample) >> AverageShift (truncating).
    - The accumulator clears.
    - Min/max and flags are then evaluated from the new average.
  - A channel ignores samples while enable=0. Writing enable=0 clears that channel's accumulator and counter.
- Over-limit mode, using unsigned compares:
  - warning sets when average >= warnHigh and clears when average < warnLow.
  - error uses the same rule with errHigh/errLow.
  - warnLow > warnHigh is legal. The flag then follows whichever condition matches, with set taking priority.
- Window mode: warning = (average > warnHigh) || (average < warnLow). error uses the same rule with errHigh/errLow. No hysteresis.
- enable=0 forces warning and error low. Sticky bits are retained.
- Sticky bits set whenever their flag is 1. If a set and a W1C land in the same cycle, the set wins.
- Simultaneous threshold write and evaluation: the evaluation uses the old threshold, and the new value applies from the next evaluation.
- Simultaneous min/max reset write and new average: the new average is loaded.

## Timing
- Reset values:
  - All flags, anyWarning, anyError, alert, cfgReady and cfgRdata = 0.
  - average = 0; min = all-ones; max = 0.
  - All thresholds = all-ones; mode = 0; enable = 0; accumulators and counters = 0.
- Completing sample accepted in cycle N:
  - average, min and max update at N+1.
  - warning/error update at N+2.
  - anyWarning, anyError and alert update at N+3.
- Back-to-back samples to the same channel, one per cycle, are accumulated without loss.
- Read data reflects register state at the cycle of the cfgRead.
- Asserting reset mid-average discards the partial accumulation. Flags drop asynchronously.

## Configuration
- OC_SENSOR_MONITOR_MINMAX_EN defined: min/max registers and logic are present.
- OC_SENSOR_MONITOR_MINMAX_EN undefined:
  - No min/max flops.
  - Offsets 1/2 read 0, and writes to them are ignored.
  - All other behaviour is unchanged.

## Structure
- oclib_pkg holds:
  - Register offset constants (SensorMonOffsetAverage..SensorMonOffsetControl).
  - Control bit index constants.
  - sensor_mon_mode_e (OverLimit, Window).
- Sub-module oc_sensor_monitor_channel contains one channel's accumulator, average, min/max, thresholds, flags and sticky bits. It is generated NumChannels times.
- The top level contains address decode, read mux, and the summary/alert registers.

## Test plan
- Averaging, NumChannels=4, AverageShift=2:
  - Stimulus: enable ch0, then send samples 10, 20, 30, 41.
  - Required: average = 25, with min = max = 25, at N+1 after the 4th sample. A read of 0x00 returns 25.
- Hysteresis, over-limit mode:
  - Setup: ch1 warnHigh=100, warnLow=90.
  - Stimulus: sequence of averages 99, 100, 95, 89.
  - Required: warning = 0, 1, 1, 0; stickyWarn = 1 and alert = 1 at N+3 of the first assertion.
  - Then: W1C of bit16 (0x00010000 OR mode/enable bits) with warning low clears stickyWarn.
- Window mode:
  - Setup: ch2 errHigh=200, errLow=50.
  - Stimulus: averages 49, 50, 200, 201.
  - Required: error = 1, 0, 0, 1; anyError follows one cycle later.
- Collisions:
  - Stimulus: a W1C of stickyWarn in the same cycle a warning evaluation sets it.
  - Required: sticky remains 1.
  - Stimulus: a write to warnHigh in the same cycle as evaluation.
  - Required: the old threshold is used.
- Robustness:
  - Stimulus: sampleChannel=7 with NumChannels=4.
  - Required: no state change.
  - Stimulus: a read of 0xFF.
  - Required: cfgRdata=0, cfgReady=1 one cycle later.
  - Stimulus: reset asserted after 2 of 4 samples, then 4 samples of 8.
  - Required: average = 8.
